mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-cycle data memory; data port wins by default.
// Define MEM_ARB_ANTISTARVE_EN to build a starvation counter that forces an instruction grant.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [DATA_W-1:0] mem_read_data
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
        $error("mem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    logic              force_i;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_we_q, cmd_we_d;
    logic              owner_q, owner_d;          // 1 = data port
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef MEM_ARB_ANTISTARVE_EN
    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign force_i = (starve_cnt_q == 8'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || i_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != 8'hFF) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        d_gnt = !rst && d_req && !force_i;
        i_gnt = !rst && i_req && (!d_req || force_i);
    end

    always_comb begin
        cmd_valid_d = i_gnt | d_gnt;
        cmd_we_d    = cmd_we_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (d_gnt) begin
            cmd_we_d    = d_we;
            owner_d     = 1'b1;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (i_gnt) begin
            cmd_we_d   = 1'b0;
            owner_d    = 1'b0;
            mem_addr_d = i_addr;
        end
        // Read data is captured at the end of the cycle the command sits on mem_*.
        i_rvalid_d = cmd_valid_q && !owner_q;
        d_rvalid_d = cmd_valid_q && owner_q;
        i_rdata_d  = i_rvalid_d ? mem_read_data : i_rdata_q;
        d_rdata_d  = (d_rvalid_d && !cmd_we_q) ? mem_read_data : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            owner_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_we_q    <= cmd_we_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_memwrite   = cmd_valid_q && cmd_we_q;
    assign mem_memread    = cmd_valid_q && !cmd_we_q;
    assign i_rvalid       = i_rvalid_q;
    assign d_rvalid       = d_rvalid_q;
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: driver pushes expected responses, a monitor pops and checks them.
// Starvation expectations follow MEM_ARB_ANTISTARVE_EN when it is defined for the bench too.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread;

    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_cycles = 0;
    logic [31:0] i_last = '0;
    logic [31:0] d_last = '0;

    typedef struct {
        logic [31:0] data;
        int          due;
        logic        wr;
    } sb_t;
    sb_t q_i[$];
    sb_t q_d[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: combinational read, write on the rising edge.
    initial for (int k = 0; k < 256; k++) mem[k] = '0;
    always @(posedge clk) if (mem_memwrite) mem[mem_addr[7:0]] <= mem_write_data;
    assign mem_read_data = mem[mem_addr[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a falling edge: drive inputs, check grants, queue expected response, advance one cycle.
    task automatic step(input logic r, input logic rq_i, input logic [31:0] a_i,
                        input logic rq_d, input logic we, input logic [31:0] a_d,
                        input logic [31:0] wd, input logic eg_i, input logic eg_d,
                        input logic push, input logic [31:0] exp_data);
        rst = r; i_req = rq_i; i_addr = a_i;
        d_req = rq_d; d_we = we; d_addr = a_d; d_wdata = wd;
        #1;
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        if (push && eg_d) q_d.push_back('{data: exp_data, due: cyc + 2, wr: we});
        if (push && eg_i) q_i.push_back('{data: exp_data, due: cyc + 2, wr: 1'b0});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero();
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_memwrite", mem_memwrite, 0);
        chk("rst_memread", mem_memread, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_write_data, 0);
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (mem_memwrite) wr_cycles++;
        if (d_rvalid) begin
            if (q_d.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL d_unexpected_rvalid: got d_rvalid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q_d.pop_front();
                chk("d_latency", cyc, e.due);
                if (e.wr) chk("d_rdata_hold_on_write", d_rdata, d_last);
                else begin
                    chk("d_rdata", d_rdata, e.data);
                    d_last = e.data;
                end
                if (!i_rvalid) chk("i_rdata_unchanged", i_rdata, i_last);
            end
        end
        if (i_rvalid) begin
            if (q_i.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL i_unexpected_rvalid: got i_rvalid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q_i.pop_front();
                chk("i_latency", cyc, e.due);
                chk("i_rdata", i_rdata, e.data);
                i_last = e.data;
                if (!d_rvalid) chk("d_rdata_unchanged", d_rdata, d_last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ei, ed;
        rst = 1; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        // Requests during reset are never granted.
        step(1, 1, 3, 1, 0, 9, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 0, 9, 0, 0, 0, 0, 0);
        check_zero();

        // Write 54 to addr 2, then read it back.
        step(0, 0, 0, 1, 1, 2, 54, 0, 1, 1, 0);
        chk("wr_memwrite", mem_memwrite, 1);
        chk("wr_mem_addr", mem_addr, 2);
        chk("wr_mem_wdata", mem_write_data, 54);
        step(0, 0, 0, 1, 0, 2, 0, 0, 1, 1, 54);
        chk("rd_memread", mem_memread, 1);
        chk("rd_memwrite", mem_memwrite, 0);
        chk("rd_mem_addr", mem_addr, 2);
        idle(3);
        chk("memwrite_cycles", wr_cycles, 1);
        chk("idle_memread", mem_memread, 0);
        chk("idle_mem_addr_held", mem_addr, 2);

        // Back-to-back writes then back-to-back reads.
        step(0, 0, 0, 1, 1, 9, 16, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 3, 62, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 3, 0, 0, 1, 1, 62);
        step(0, 0, 0, 1, 0, 9, 0, 0, 1, 1, 16);
        idle(3);

        // Simultaneous requests: data first, instruction the next cycle.
        step(0, 1, 3, 1, 0, 9, 0, 0, 1, 1, 16);
        step(0, 1, 3, 0, 0, 0, 0, 1, 0, 1, 62);
        idle(3);

        // Both ports requesting continuously.
        for (int k = 1; k <= 8; k++) begin
`ifdef MEM_ARB_ANTISTARVE_EN
            ei = (k == 5);
`else
            ei = 1'b0;
`endif
            ed = !ei;
            step(0, 1, 3, 1, 0, 9, 0, ei, ed, 1, ei ? 32'd62 : 32'd16);
        end
        idle(3);

        // Reset while a read of addr 3 is on mem_*: its response must vanish.
        step(0, 0, 0, 1, 0, 3, 0, 0, 1, 0, 0);
        chk("pre_rst_memread", mem_memread, 1);
        chk("pre_rst_mem_addr", mem_addr, 3);
        d_last = '0;
        i_last = '0;
        step(1, 1, 3, 1, 0, 9, 0, 0, 0, 0, 0);
        check_zero();
        step(0, 0, 0, 1, 0, 3, 0, 0, 1, 1, 62);
        idle(4);

        chk("q_i_drained", q_i.size(), 0);
        chk("q_d_drained", q_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
